// File: rtl/pe_array_pkg.sv
// Shared sizing constants and scheduler state encoding for the PE-array feed path.
package pe_array_pkg;

  localparam int unsigned ROWS  = 16;
  localparam int unsigned ROW_W = 256;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDone   = 2'd2
  } state_e;

endpackage

// File: rtl/row_buffer_mux.sv
// Whole-matrix holding register with a single row-wide read port; row 0 is the top slice.
module row_buffer_mux #(
  parameter int unsigned ROWS  = pe_array_pkg::ROWS,
  parameter int unsigned ROW_W = pe_array_pkg::ROW_W,
  parameter int unsigned IDX_W = $clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [ROWS*ROW_W-1:0] i_data,
  input  logic [IDX_W-1:0]      i_sel,
  output logic [ROW_W-1:0]      o_row
);

  logic [ROWS*ROW_W-1:0] r_buf;
  logic [IDX_W-1:0]      w_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
    end else if (i_load) begin
      r_buf <= i_data;
    end
  end

  // Row 0 occupies the most significant slice, so invert the index before slicing.
  assign w_slot = IDX_W'(ROWS - 1) - i_sel;
  assign o_row  = r_buf[w_slot*ROW_W +: ROW_W];

endmodule

// File: rtl/matrix_row_sched.sv
// Latches one matrix and hands it to the PE array one row slice per valid/ready handshake.
module matrix_row_sched #(
  parameter int unsigned ROWS  = pe_array_pkg::ROWS,
  parameter int unsigned ROW_W = pe_array_pkg::ROW_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort,
  input  logic                  mat_valid,
  output logic                  mat_ready,
  input  logic [ROWS*ROW_W-1:0] mat_data,
  input  logic [4:0]            num_rows,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic [ROW_W-1:0]      row_data,
  output logic [3:0]            row_idx,
  output logic                  row_last,
  output logic                  busy,
  output logic                  done
);

  pe_array_pkg::state_e r_state, w_state_next;

  logic [3:0] r_idx;
  logic [3:0] r_last_idx;
  logic [3:0] w_last_idx_in;
  logic       w_accept;
  logic       w_hs;
  logic       w_at_last;

  assign w_accept  = (r_state == pe_array_pkg::StIdle) && mat_valid && !abort;
  assign w_hs      = row_valid && row_ready;
  assign w_at_last = (r_idx == r_last_idx);

  // Zero or an oversize request both mean "all rows".
  always_comb begin
    w_last_idx_in = 4'(ROWS - 1);
    if (num_rows != 5'd0 && 32'(num_rows) <= ROWS) begin
      w_last_idx_in = 4'(num_rows - 5'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= pe_array_pkg::StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      pe_array_pkg::StIdle: begin
        if (w_accept) w_state_next = pe_array_pkg::StStream;
      end
      pe_array_pkg::StStream: begin
        if (abort) begin
          w_state_next = pe_array_pkg::StIdle;
        end else if (w_hs && w_at_last) begin
          w_state_next = pe_array_pkg::StDone;
        end
      end
      pe_array_pkg::StDone: w_state_next = pe_array_pkg::StIdle;
      default:              w_state_next = pe_array_pkg::StIdle;
    endcase
  end

  always_comb begin
    mat_ready = 1'b0;
    row_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      pe_array_pkg::StIdle:   mat_ready = 1'b1;
      pe_array_pkg::StStream: begin
        row_valid = 1'b1;
        busy      = 1'b1;
      end
      pe_array_pkg::StDone:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_last_idx <= 4'(ROWS - 1);
    end else if (w_accept) begin
      r_idx      <= '0;
      r_last_idx <= w_last_idx_in;
    end else if (abort) begin
      r_idx      <= '0;
    end else if (w_hs && !w_at_last) begin
      r_idx      <= r_idx + 4'd1;
    end
  end

  assign row_idx  = r_idx;
  assign row_last = w_at_last && row_valid;

  row_buffer_mux #(
    .ROWS  (ROWS),
    .ROW_W (ROW_W),
    .IDX_W (4)
  ) u_row_buffer_mux (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_data (mat_data),
    .i_sel  (r_idx),
    .o_row  (row_data)
  );

endmodule

// File: tb/tb_matrix_row_sched.sv
// Directed, table-driven bench for matrix_row_sched with hand sequences for abort and reset.
module tb_matrix_row_sched;

  localparam int unsigned ROWS  = 16;
  localparam int unsigned ROW_W = 256;
  localparam int unsigned MAT_W = ROWS * ROW_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             abort;
  logic             mat_valid;
  logic             mat_ready;
  logic [MAT_W-1:0] mat_data;
  logic [4:0]       num_rows;
  logic             row_valid;
  logic             row_ready;
  logic [ROW_W-1:0] row_data;
  logic [3:0]       row_idx;
  logic             row_last;
  logic             busy;
  logic             done;

  matrix_row_sched #(
    .ROWS  (ROWS),
    .ROW_W (ROW_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .mat_valid (mat_valid),
    .mat_ready (mat_ready),
    .mat_data  (mat_data),
    .num_rows  (num_rows),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_last  (row_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ready;
    logic       valid;
    logic [3:0] idx;
    logic       last;
    logic       dn;
    logic       mready;
    logic       bsy;
  } vec_t;

  vec_t vecs[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int hs_cnt   = 0;

  logic [MAT_W-1:0] m1, m2, m_lat;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (row_valid && row_ready) hs_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [ROW_W-1:0] act,
                       input logic [ROW_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] row_of(input logic [MAT_W-1:0] m, input int k);
    return m[(ROWS-1-k)*ROW_W +: ROW_W];
  endfunction

  function automatic logic [MAT_W-1:0] rand_mat();
    logic [MAT_W-1:0] m;
    for (int j = 0; j < MAT_W / 32; j++) m[j*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [MAT_W-1:0] m, input logic [4:0] nr);
    mat_valid = 1'b1;
    mat_data  = m;
    num_rows  = nr;
    tick();
    mat_valid = 1'b0;
  endtask

  // Index and data are only defined while a row is presented.
  task automatic expect_state(input string tag, input logic v, input logic [3:0] idx,
                              input logic last, input logic dn, input logic mr,
                              input logic bz, input logic [MAT_W-1:0] m);
    check({tag, ".row_valid"}, ROW_W'(row_valid), ROW_W'(v));
    check({tag, ".row_last"}, ROW_W'(row_last), ROW_W'(last));
    check({tag, ".done"}, ROW_W'(done), ROW_W'(dn));
    check({tag, ".mat_ready"}, ROW_W'(mat_ready), ROW_W'(mr));
    check({tag, ".busy"}, ROW_W'(busy), ROW_W'(bz));
    if (v) begin
      check({tag, ".row_idx"}, ROW_W'(row_idx), ROW_W'(idx));
      check({tag, ".row_data"}, row_data, row_of(m, int'(idx)));
    end
  endtask

  task automatic run_vecs(input string name, input logic [MAT_W-1:0] m);
    foreach (vecs[i]) begin
      row_ready = vecs[i].ready;
      expect_state($sformatf("%s[%0d]", name, i), vecs[i].valid, vecs[i].idx, vecs[i].last,
                   vecs[i].dn, vecs[i].mready, vecs[i].bsy, m);
      tick();
    end
    row_ready = 1'b0;
  endtask

  task automatic build_full();
    vecs.delete();
    for (int i = 0; i < 16; i++) vecs.push_back('{1'b1, 1'b1, 4'(i), (i == 15), 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0});
  endtask

  // Ready pattern 1,0,0 repeating: each row after the first stalls for two cycles.
  task automatic build_backpressure();
    vecs.delete();
    for (int c = 0; c < 10; c++) begin
      vecs.push_back('{(c % 3 == 0), 1'b1, 4'((c + 2) / 3), ((c + 2) / 3 == 3), 1'b0, 1'b0, 1'b1});
    end
    vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0});
  endtask

  initial begin
    logic [15:0] w16;
    int d0, h0;

    for (int k = 0; k < 16; k++) begin
      w16 = 16'(16'h0100 * k + k);
      m1[(15-k)*ROW_W +: ROW_W] = {16{w16}};
    end
    m2 = rand_mat();

    rst_n = 1'b0; abort = 1'b0; mat_valid = 1'b0; mat_data = '0;
    num_rows = '0; row_ready = 1'b0;
    #12;
    expect_state("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, m1);
    check("reset.row_idx", ROW_W'(row_idx), '0);
    check("reset.row_data", row_data, '0);
    rst_n = 1'b1;
    tick();

    // Full matrix, num_rows=0 means all 16 rows.
    d0 = done_cnt;
    accept(m1, 5'd0);
    build_full();
    run_vecs("full", m1);
    check("full.done_count", ROW_W'(done_cnt - d0), ROW_W'(1));

    // Backpressure with four rows.
    d0 = done_cnt; h0 = hs_cnt;
    accept(m2, 5'd4);
    build_backpressure();
    run_vecs("bp", m2);
    check("bp.handshakes", ROW_W'(hs_cnt - h0), ROW_W'(4));
    check("bp.done_count", ROW_W'(done_cnt - d0), ROW_W'(1));

    // Single row: row_last on the first row, done right after its handshake.
    accept(m2, 5'd1);
    expect_state("one.first", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, m2);
    tick();
    expect_state("one.stall", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, m2);
    row_ready = 1'b1;
    tick();
    row_ready = 1'b0;
    expect_state("one.done", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, m2);
    tick();
    expect_state("one.idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, m2);

    // Oversize request behaves as 16 rows.
    accept(m2, 5'd20);
    build_full();
    run_vecs("over", m2);

    // Abort in IDLE beats mat_valid.
    abort = 1'b1; mat_valid = 1'b1; mat_data = m2; num_rows = 5'd0;
    tick();
    abort = 1'b0; mat_valid = 1'b0;
    expect_state("abort_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, m2);

    // Abort mid-stream at row 7.
    d0 = done_cnt;
    accept(m1, 5'd0);
    row_ready = 1'b1;
    repeat (7) tick();
    expect_state("abort.at7", 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, m1);
    abort = 1'b1;
    tick();
    abort = 1'b0; row_ready = 1'b0;
    expect_state("abort.idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, m1);
    tick();
    check("abort.no_done", ROW_W'(done_cnt - d0), ROW_W'(0));
    accept(m2, 5'd2);
    row_ready = 1'b1;
    expect_state("abort.next0", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, m2);
    tick();
    expect_state("abort.next1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, m2);
    tick();
    row_ready = 1'b0;
    expect_state("abort.done", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, m2);
    tick();

    // mat_data churns every cycle while streaming; rows must come from the latched copy.
    m_lat = rand_mat();
    accept(m_lat, 5'd0);
    row_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mat_data = rand_mat();
      check($sformatf("churn[%0d].row_idx", i), ROW_W'(row_idx), ROW_W'(i));
      check($sformatf("churn[%0d].row_data", i), row_data, row_of(m_lat, i));
      tick();
    end
    row_ready = 1'b0;
    tick();

    // Asynchronous reset between edges at row 5.
    accept(m1, 5'd0);
    row_ready = 1'b1;
    repeat (5) tick();
    expect_state("rst.at5", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, m1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("rst.async", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, m1);
    check("rst.row_idx", ROW_W'(row_idx), '0);
    check("rst.row_data", row_data, '0);
    row_ready = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    expect_state("rst.after", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, m1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
